sc_psrandom_checker: RTL
========================

Name: sc_psrandom_checker

Overview:
Receive-side companion of the 8-bit pseudo-random pattern generator (Fibonacci LFSR, shift-left, feedback = b7^b5^b3^b0, seed 0x81).
- Accepts the parallel pattern word by word.
- Self-synchronises to the sequence, then flywheels the expected value.
- Flags and counts mismatches.
- Used as link/datapath BIST checker at the far end of the generator's bus.

Parameters:
RegGENERAL_DATAWIDTH, 8, pattern word width; only 8 supported because the taps are fixed.
LOCK_COUNT, 4, consecutive correct predictions needed to declare lock (1..15).
LOSS_COUNT, 3, consecutive mismatches in LOCKED that drop lock (1..15).
ERRCNT_WIDTH, 16, width of the saturating error counter.

Ports:
SC_PSRANDOM_CLOCK_50  in  1  system clock; all state updates on rising edge.
SC_PSRANDOM_RESET_InHigh  in  1  asynchronous, active-high reset.
SC_PSRANDOMCHK_data_InBUS  in  8  received pattern word.
SC_PSRANDOMCHK_valid_InHigh  in  1  data_InBUS holds a new word this cycle.
SC_PSRANDOMCHK_clear_InHigh  in  1  synchronous clear of the error counter.
SC_PSRANDOMCHK_locked_Out  out  1  checker is in LOCKED.
SC_PSRANDOMCHK_error_Out  out  1  one-cycle pulse on a mismatched word while LOCKED.
SC_PSRANDOMCHK_errcount_OutBUS  out  ERRCNT_WIDTH  saturating mismatch count.

Behaviour:
- Next function: next(x) = {x[6:0], x[7]^x[5]^x[3]^x[0]}.
- Internal state:
  - PRED[7:0]: expected word.
  - seeded: PRED is valid.
  - match_cnt, miss_cnt: 4-bit counters.
  - FSM state: HUNT or LOCKED.
- Reset (async): state=HUNT, PRED=0x00, seeded=0, match_cnt=0, miss_cnt=0, locked=0, error=0, errcount=0.
- All outputs are registered. Effects of a valid word at edge N are visible after edge N. error_Out is 0 in any cycle not following a LOCKED mismatch.
- No valid: all state holds; error_Out=0.
- HUNT, on valid with word D:
  - If seeded and D==PRED: match_cnt+1. Otherwise match_cnt=0.
  - PRED<=next(D); seeded<=(D!=0x00). A zero word is a lock-up value and never seeds.
  - If the increment makes match_cnt==LOCK_COUNT: state<=LOCKED, locked<=1, miss_cnt<=0.
  - No errors are flagged or counted in HUNT.
- LOCKED, on valid with word D:
  - Flywheel: PRED<=next(PRED), regardless of D.
  - D==PRED: miss_cnt<=0.
  - D!=PRED: error<=1 for one cycle; errcount+1, saturating at all-ones; miss_cnt+1.
  - If miss_cnt reaches LOSS_COUNT: state<=HUNT, locked<=0, match_cnt<=0, seeded<=0. Errors on that final word are still counted.
- clear_InHigh:
  - Sets errcount<=0 at the next edge.
  - Clear has priority over a simultaneous increment: result 0, error pulse still asserted.
  - Does not affect the FSM.
- Reset mid-operation: immediate return to reset values. The first valid word after reset release seeds PRED.

Decomposition:
- Shared package: PSRANDOM_WIDTH=8, PSRANDOM_SEED=8'h81, tap constants, next-value function.
  - The package is also adopted by the generator so both ends share one polynomial definition.
  - FSM state encoding: HUNT=1'b0, LOCKED=1'b1.
- One natural sub-module: sc_psrandom_errcounter, the saturating counter with synchronous clear and priority rule.

Test Plan:
1. Reset, then valid words 81,02,04,08,11 on consecutive cycles (LOCK_COUNT=4) -> locked_Out=1 after the 0x11 edge; errcount=0; error never asserted.
2. Locked, expect 0x23; send 0x00, then 0x46 -> one error pulse after the 0x00 edge, errcount=1; 0x46 matches (flywheel), locked stays 1.
3. Locked; send three wrong words (LOSS_COUNT=3) -> three error pulses, errcount=3, locked_Out=0 after the third. Then resend 04,08,11,23,46 -> relocks after 0x46.
4. In HUNT, feed 0x00 repeatedly, then 81,02,04,08,11 -> no lock during zeros; lock exactly after 0x11.
5. Force errcount to 0xFFFE with a stream of mismatches while locked (LOSS_COUNT=15, resynchronised periodically), then 3 more mismatches -> saturates at 0xFFFF. Then assert clear together with a mismatch -> errcount=0 and error pulse=1.
6. Assert reset asynchronously mid-LOCKED, between clock edges -> locked, error and errcount go 0 without a clock edge. After release, valid gaps (valid=0 cycles) inside a lock sequence do not break match counting.

Source files
------------

// File: rtl/sc_psrandom_pkg.sv
// Shared definition of the 8-bit pseudo-random pattern polynomial used by both
// the generator and the checker, plus the checker FSM encoding.
package sc_psrandom_pkg;

    localparam int                          PSRANDOM_WIDTH = 8;
    localparam logic [PSRANDOM_WIDTH-1:0]   PSRANDOM_SEED  = 8'h81;
    // Feedback taps b7, b5, b3, b0 of the shift-left Fibonacci LFSR.
    localparam logic [PSRANDOM_WIDTH-1:0]   PSRANDOM_TAPS  = 8'b1010_1001;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } psrandom_state_e;

    function automatic logic [PSRANDOM_WIDTH-1:0] psrandom_next(input logic [PSRANDOM_WIDTH-1:0] x);
        return {x[PSRANDOM_WIDTH-2:0], ^(x & PSRANDOM_TAPS)};
    endfunction

endpackage

// File: rtl/sc_psrandom_errcounter.sv
// Saturating mismatch counter; a synchronous clear wins over a same-cycle increment.
module sc_psrandom_errcounter #(
    parameter int WIDTH = 16
) (
    input  logic             SC_PSRANDOM_CLOCK_50,
    input  logic             SC_PSRANDOM_RESET_InHigh,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state is always written with non-blocking assignments.
    always_ff @(posedge SC_PSRANDOM_CLOCK_50 or posedge SC_PSRANDOM_RESET_InHigh) begin
        if (SC_PSRANDOM_RESET_InHigh) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/sc_psrandom_checker.sv
// Receive-side pattern checker: self-synchronises to the LFSR sequence, then
// flywheels the expected word and flags/counts mismatches while locked.
module sc_psrandom_checker
    import sc_psrandom_pkg::*;
#(
    parameter int RegGENERAL_DATAWIDTH = 8,
    parameter int LOCK_COUNT           = 4,
    parameter int LOSS_COUNT           = 3,
    parameter int ERRCNT_WIDTH         = 16
) (
    input  logic                            SC_PSRANDOM_CLOCK_50,
    input  logic                            SC_PSRANDOM_RESET_InHigh,
    input  logic [RegGENERAL_DATAWIDTH-1:0] SC_PSRANDOMCHK_data_InBUS,
    input  logic                            SC_PSRANDOMCHK_valid_InHigh,
    input  logic                            SC_PSRANDOMCHK_clear_InHigh,
    output logic                            SC_PSRANDOMCHK_locked_Out,
    output logic                            SC_PSRANDOMCHK_error_Out,
    output logic [ERRCNT_WIDTH-1:0]         SC_PSRANDOMCHK_errcount_OutBUS
);

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_CNT = 4'(LOSS_COUNT);

    psrandom_state_e           state_q, state_d;
    logic [PSRANDOM_WIDTH-1:0] pred_q, pred_d;
    logic                      seeded_q, seeded_d;
    logic [3:0]                match_q, match_d, match_inc;
    logic [3:0]                miss_q, miss_d, miss_inc;
    logic                      error_q, error_d;
    logic                      hit;

    always_ff @(posedge SC_PSRANDOM_CLOCK_50 or posedge SC_PSRANDOM_RESET_InHigh) begin
        if (SC_PSRANDOM_RESET_InHigh) begin
            state_q  <= HUNT;
            pred_q   <= '0;
            seeded_q <= 1'b0;
            match_q  <= '0;
            miss_q   <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pred_q   <= pred_d;
            seeded_q <= seeded_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            error_q  <= error_d;
        end
    end

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        pred_d    = pred_q;
        seeded_d  = seeded_q;
        match_d   = match_q;
        miss_d    = miss_q;
        error_d   = 1'b0;
        hit       = (SC_PSRANDOMCHK_data_InBUS == pred_q);
        match_inc = match_q + 4'd1;
        miss_inc  = miss_q + 4'd1;

        if (SC_PSRANDOMCHK_valid_InHigh) begin
            case (state_q)
                HUNT: begin
                    // Reseed from every received word; a zero word is the LFSR lock-up value.
                    match_d  = (seeded_q && hit) ? match_inc : 4'd0;
                    pred_d   = psrandom_next(SC_PSRANDOMCHK_data_InBUS);
                    seeded_d = (SC_PSRANDOMCHK_data_InBUS != '0);
                    if (seeded_q && hit && (match_inc == LOCK_CNT)) begin
                        state_d = LOCKED;
                        miss_d  = 4'd0;
                    end
                end
                LOCKED: begin
                    pred_d = psrandom_next(pred_q);
                    if (hit) begin
                        miss_d = 4'd0;
                    end else begin
                        error_d = 1'b1;
                        miss_d  = miss_inc;
                        if (miss_inc == LOSS_CNT) begin
                            state_d  = HUNT;
                            match_d  = 4'd0;
                            seeded_d = 1'b0;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    sc_psrandom_errcounter #(
        .WIDTH (ERRCNT_WIDTH)
    ) u_errcounter (
        .SC_PSRANDOM_CLOCK_50     (SC_PSRANDOM_CLOCK_50),
        .SC_PSRANDOM_RESET_InHigh (SC_PSRANDOM_RESET_InHigh),
        .inc                      (error_d),
        .clear                    (SC_PSRANDOMCHK_clear_InHigh),
        .count                    (SC_PSRANDOMCHK_errcount_OutBUS)
    );

    assign SC_PSRANDOMCHK_locked_Out = (state_q == LOCKED);
    assign SC_PSRANDOMCHK_error_Out  = error_q;

endmodule
